axis_window_crop: RTL and testbench

- Per-stream window cropper on the camera video path, directly downstream of the frame-sync/config controller.
- Consumes an AXI4-Stream video frame (tuser = SOF, tlast = EOL) and the controller's sN_win_left/top/width/height outputs.
- Forwards only the pixels inside the window, re-framed with its own SOF/EOL, to the scaler stage.
- Window parameters are sampled once per frame at SOF, so mid-frame register changes never tear a frame.

---
 rtl/axis_window_crop_pkg.sv | 22 ++
 rtl/axis_reg_slice.sv | 33 +++
 rtl/axis_window_crop.sv | 124 ++++++++++++
 tb/tb_axis_window_crop.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_window_crop_pkg.sv
// Shared types for the window cropper and its output register slice.
//   crop_state_e : frame-scan state encoding
//   win_cfg_t    : window configuration latched at start of frame
package axis_window_crop_pkg;

  localparam int WIN_WBITS = 12;
  localparam int WIN_HBITS = 12;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DRAIN    = 2'd2
  } crop_state_e;

  typedef struct packed {
    logic [WIN_WBITS-1:0] left;
    logic [WIN_WBITS-1:0] width;
    logic [WIN_HBITS-1:0] top;
    logic [WIN_HBITS-1:0] height;
  } win_cfg_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-beat AXI4-Stream output register.
//   clk, reset           : clock, async active-high reset
//   s_valid/s_data/s_ready : upstream side; s_ready = ~m_valid | m_ready
//   m_valid/m_data/m_ready : downstream side; beat held stable until m_ready
module axis_reg_slice #(
  parameter int C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [C_WIDTH-1:0] s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic [C_WIDTH-1:0] m_data,
  input  logic               m_ready
);

  // Can take a new beat whenever the register is empty or is draining now.
  assign s_ready = ~m_valid | m_ready;

  // NOTE: state is written with <= so every register samples pre-edge values;
  // the data register is reset too, so the outputs read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end

endmodule

// File: rtl/axis_window_crop.sv
// Crops a rectangular window out of an AXI4-Stream video frame
// (tuser = SOF, tlast = EOL) and re-frames it with its own SOF/EOL.
//   clk, reset                 : clock, async active-high reset
//   win_left/width/top/height  : window, sampled on each accepted SOF beat
//   s_axis_*                   : input video stream
//   m_axis_*                   : cropped output stream (one register stage)
//   frame_done                 : pulse after the last window pixel's handshake
module axis_window_crop
  import axis_window_crop_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = WIN_WBITS,
  parameter int C_IMG_HBITS   = WIN_HBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [C_IMG_WBITS-1:0]   win_left,
  input  logic [C_IMG_WBITS-1:0]   win_width,
  input  logic [C_IMG_HBITS-1:0]   win_top,
  input  logic [C_IMG_HBITS-1:0]   win_height,
  input  logic                     s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     frame_done
);

  localparam int XW  = C_IMG_WBITS + 1;
  localparam int YW  = C_IMG_HBITS + 1;
  localparam int PAY = C_PIXEL_WIDTH + 3;   // {win_end, user, last, data}

  crop_state_e             state;
  win_cfg_t                cfg, cur_cfg;
  logic [C_IMG_WBITS-1:0]  col, cur_col;
  logic [C_IMG_HBITS-1:0]  row, cur_row;
  logic                    first_sent, cur_first;
  logic                    accept, in_frame, keep, last_col, win_end, empty_win;
  logic [XW-1:0]           col_end;         // exclusive right bound
  logic [YW-1:0]           row_end;         // exclusive bottom bound
  logic                    slice_ready;
  logic [PAY-1:0]          slice_in, slice_out;

  assign s_axis_tready = slice_ready;
  assign accept        = s_axis_tvalid & slice_ready;

  // An SOF beat is pixel (0,0) of a new frame, judged against the window
  // being latched on this same beat rather than the stale shadow copy.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_cfg   = cfg;
    cur_col   = col;
    cur_row   = row;
    cur_first = first_sent;
    if (s_axis_tuser) begin
      cur_cfg   = '{left: win_left, width: win_width, top: win_top, height: win_height};
      cur_col   = '0;
      cur_row   = '0;
      cur_first = 1'b0;
    end
    in_frame  = s_axis_tuser | (state == ACTIVE);
    // One extra bit so left+width never wraps.
    col_end   = {1'b0, cur_cfg.left} + {1'b0, cur_cfg.width};
    row_end   = {1'b0, cur_cfg.top} + {1'b0, cur_cfg.height};
    empty_win = (cur_cfg.width == '0) | (cur_cfg.height == '0);
    keep      = in_frame
              & (cur_col >= cur_cfg.left) & ({1'b0, cur_col} < col_end)
              & (cur_row >= cur_cfg.top)  & ({1'b0, cur_row} < row_end);
    // A short line clips the window on the right: input EOL ends the row.
    last_col  = ({1'b0, cur_col} == col_end - XW'(1)) | s_axis_tlast;
    win_end   = keep & last_col & ({1'b0, cur_row} == row_end - YW'(1));
  end

  assign slice_in = {win_end, keep & ~cur_first, last_col, s_axis_tdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SOF;
      cfg        <= '0;
      col        <= '0;
      row        <= '0;
      first_sent <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_axis_tvalid & m_axis_tready & slice_out[PAY-1];
      if (accept) begin
        if (s_axis_tuser) cfg <= cur_cfg;
        if (in_frame) begin
          first_sent <= cur_first | keep;
          // Counters saturate instead of wrapping on malformed frames.
          if (s_axis_tlast) begin
            col <= '0;
            row <= (&cur_row) ? cur_row : cur_row + C_IMG_HBITS'(1);
          end else begin
            col <= (&cur_col) ? cur_col : cur_col + C_IMG_WBITS'(1);
            row <= cur_row;
          end
          state <= (win_end | empty_win) ? DRAIN : ACTIVE;
        end
      end
    end
  end

  axis_reg_slice #(.C_WIDTH(PAY)) u_out_slice (
    .clk     (clk),
    .reset   (reset),
    .s_valid (accept & keep),
    .s_data  (slice_in),
    .s_ready (slice_ready),
    .m_valid (m_axis_tvalid),
    .m_data  (slice_out),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = slice_out[C_PIXEL_WIDTH-1:0];
  assign m_axis_tlast = slice_out[C_PIXEL_WIDTH];
  assign m_axis_tuser = slice_out[C_PIXEL_WIDTH+1];

endmodule

// File: tb/tb_axis_window_crop.sv
// Self-checking bench for axis_window_crop. Frames are generated with known
// pixel coordinates; the expected output is derived directly from the window
// rectangle and compared against beats captured on the output handshake.
module tb_axis_window_crop;

  localparam int PW = 8;
  localparam int WB = 12;
  localparam int HB = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [WB-1:0] win_left, win_width;
  logic [HB-1:0] win_top, win_height;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic [PW-1:0] s_tdata;
  logic          m_tvalid, m_tuser, m_tlast, m_tready, frame_done;
  logic [PW-1:0] m_tdata;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap_q[$];
  int    exp_done, done_cnt, cyc, last_hs_cyc, done_cyc;
  int    passed = 0;
  int    total  = 0;
  int    rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random, 3 stalled
  bit    viol_en = 1'b0;
  int    viol_cnt = 0;

  axis_window_crop #(.C_PIXEL_WIDTH(PW), .C_IMG_WBITS(WB), .C_IMG_HBITS(HB)) dut (
    .clk           (clk),
    .reset         (reset),
    .win_left      (win_left),
    .win_width     (win_width),
    .win_top       (win_top),
    .win_height    (win_height),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled mid-cycle while inputs are stable.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (m_tvalid && m_tready) begin
          cap_q.push_back('{data: m_tdata, user: m_tuser, last: m_tlast});
          last_hs_cyc = cyc;
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (viol_en && (s_tready !== (!m_tvalid || m_tready))) viol_cnt++;
      end
    end
  end

  // Downstream ready generator.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Called and returns at posedge+1.
  task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l);
    bit ok;
    int guard = 0;
    while ($urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    do begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", guard);
    end
    s_tvalid = 1'b0;
  endtask

  // Sends a w x h frame (only the first n beats when n >= 0) and records the
  // expected cropped stream. mid_w >= 0 rewrites win_width right after SOF.
  task automatic send_frame(input int w, input int h, input int n,
                            input int l, input int ww, input int t, input int hh,
                            input int mid_w);
    int k = 0;
    bit first = 1'b1;
    logic [PW-1:0] d;
    bit eol, keep, lst;
    win_left = WB'(l); win_width = WB'(ww); win_top = HB'(t); win_height = HB'(hh);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n >= 0 && k >= n) return;
        d    = PW'($urandom);
        eol  = (c == w - 1);
        keep = (c >= l) && (c < l + ww) && (r >= t) && (r < t + hh);
        lst  = (c == l + ww - 1) || eol;
        if (keep) begin
          exp_q.push_back('{data: d, user: first, last: lst});
          if (r == t + hh - 1 && lst) exp_done++;
          first = 1'b0;
        end
        send_beat(d, (r == 0 && c == 0), eol);
        if (k == 0 && mid_w >= 0) win_width = WB'(mid_w);
        k++;
      end
    end
  endtask

  task automatic clear_scoreboard();
    exp_q.delete(); cap_q.delete();
    exp_done = 0; done_cnt = 0;
  endtask

  task automatic settle();
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (m_tvalid !== 1'b0)   $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); else passed++;
    total++; if (m_tuser !== 1'b0)    $display("FAIL reset_m_tuser: got %b want 0", m_tuser); else passed++;
    total++; if (m_tlast !== 1'b0)    $display("FAIL reset_m_tlast: got %b want 0", m_tlast); else passed++;
    total++; if (m_tdata !== '0)      $display("FAIL reset_m_tdata: got %h want 0", m_tdata); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
    total++; if (s_tready !== 1'b1)   $display("FAIL reset_s_tready: got %b want 1", s_tready); else passed++;
  endtask

  task automatic test_basic();
    clear_scoreboard();
    rdy_mode = 0;
    send_frame(8, 4, -1, 2, 3, 1, 2, -1);
    settle();
    total++; if (cap_q.size() != 6) $display("FAIL basic_count: got %0d beats want 6", cap_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else passed++;
    total++; if (done_cyc != last_hs_cyc + 1) $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, last_hs_cyc + 1); else passed++;
  endtask

  task automatic test_backpressure();
    clear_scoreboard();
    viol_cnt = 0; viol_en = 1'b1;
    rdy_mode = 1;
    send_frame(8, 4, -1, 2, 3, 1, 2, -1);
    settle();
    viol_en = 1'b0;
    total++; if (cap_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d beats want %0d", cap_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != exp_done) $display("FAIL bp_done: got %0d want %0d", done_cnt, exp_done); else passed++;
    total++; if (viol_cnt != 0) $display("FAIL bp_s_tready_rule: got %0d violations want 0", viol_cnt); else passed++;
  endtask

  task automatic test_right_clip();
    clear_scoreboard();
    rdy_mode = 0;
    send_frame(8, 3, -1, 6, 5, 0, 2, -1);
    settle();
    total++; if (cap_q.size() != 4) $display("FAIL clip_count: got %0d beats want 4", cap_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL clip_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL clip_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_mid_change();
    clear_scoreboard();
    rdy_mode = 2;
    send_frame(8, 3, -1, 1, 3, 0, 3, 4);
    send_frame(8, 3, -1, 1, 4, 0, 3, -1);
    settle();
    total++; if (cap_q.size() != 21) $display("FAIL midchg_count: got %0d beats want 21", cap_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL midchg_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 2) $display("FAIL midchg_done: got %0d want 2", done_cnt); else passed++;
  endtask

  task automatic test_resync();
    clear_scoreboard();
    rdy_mode = 0;
    send_frame(8, 4, 2 * 8 + 5, 2, 3, 1, 3, -1);   // next SOF lands at (5,2)
    send_frame(8, 4, -1, 2, 3, 1, 2, -1);
    settle();
    total++; if (cap_q.size() != exp_q.size()) $display("FAIL resync_count: got %0d beats want %0d", cap_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL resync_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL resync_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_empty_window();
    clear_scoreboard();
    rdy_mode = 2;
    send_frame(8, 3, -1, 2, 0, 0, 3, -1);
    send_frame(8, 3, -1, 2, 3, 1, 0, -1);
    settle();
    total++; if (cap_q.size() != 0) $display("FAIL empty_count: got %0d beats want 0", cap_q.size()); else passed++;
    total++; if (done_cnt != 0) $display("FAIL empty_done: got %0d want 0", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    clear_scoreboard();
    rdy_mode = 3;
    m_tready = 1'b0;
    send_frame(8, 4, 1, 0, 8, 0, 4, -1);
    @(negedge clk);
    total++; if (m_tvalid !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", m_tvalid); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (m_tvalid !== 1'b0) $display("FAIL rstmid_m_tvalid: got %b want 0", m_tvalid); else passed++;
    total++; if (s_tready !== 1'b1) $display("FAIL rstmid_s_tready: got %b want 1", s_tready); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_scoreboard();
    rdy_mode = 0;
    send_frame(6, 3, -1, 1, 2, 1, 2, -1);
    settle();
    total++; if (cap_q.size() != 4) $display("FAIL rstmid_count: got %0d beats want 4", cap_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL rstmid_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_random();
    int w, h, l, ww, t, hh;
    for (int f = 0; f < 8; f++) begin
      clear_scoreboard();
      if (f == 0) begin
        w = 1; h = 3; l = 0; ww = 1; t = 0; hh = 2;       // 1-pixel-wide image
      end else begin
        w  = $urandom_range(1, 10); h  = $urandom_range(1, 6);
        l  = $urandom_range(0, w);  ww = $urandom_range(0, w + 1);
        t  = $urandom_range(0, h);  hh = $urandom_range(0, h);
      end
      rdy_mode = 2;
      send_frame(w, h, -1, l, ww, t, hh, -1);
      settle();
      total++; if (cap_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", f, cap_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        total++; if (cap_q[i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d: got %h want %h", f, i, cap_q[i], exp_q[i]); else passed++;
      end
      total++; if (done_cnt != exp_done) $display("FAIL rand%0d_done: got %0d want %0d", f, done_cnt, exp_done); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    win_left = '0; win_width = '0; win_top = '0; win_height = '0;
    exp_done = 0; done_cnt = 0; last_hs_cyc = 0; done_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_backpressure();
    test_right_clip();
    test_mid_change();
    test_resync();
    test_empty_window();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
